// File: rtl/plc_pkg.sv
// Shared types and constants for the programmable logic cell (LUT with serial reconfiguration).
package plc_pkg;

  localparam int unsigned N_IN_MAX = 6;

  // Minterms 0, 4 and 5 set for the 3-input build.
  localparam logic [7:0] TT_DEFAULT_3 = 8'b0011_0001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } plc_state_e;

endpackage

// File: rtl/prog_logic_cell_if.sv
// Handshake bundle for prog_logic_cell: config stream, operand stream and result stream.
interface prog_logic_cell_if #(
  parameter int unsigned N_IN = 3
) ();

  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            in_valid;
  logic [N_IN-1:0] in_x;
  logic            in_ready;
  logic            out_valid;
  logic            out_y;
  logic            out_ready;

  modport master (
    output cfg_valid, cfg_bit, in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y
  );

  modport slave (
    input  cfg_valid, cfg_bit, in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_y
  );

endinterface

// File: rtl/plc_tt_loader.sv
// Shadow truth-table shift register and beat counter; flags the beat that completes a table.
module plc_tt_loader #(
  parameter int unsigned N_IN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,
  input  logic                  clear,
  input  logic                  cfg_bit,
  output logic [(1<<N_IN)-1:0]  shadow,
  output logic                  done_c
);

  localparam int unsigned W  = 1 << N_IN;
  localparam int unsigned CW = N_IN + 1;

  logic [CW-1:0] count;

  // Minterm 0 arrives first, so it ends up in bit 0 after W shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      shadow <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (beat) begin
        count <= count + CW'(1);
      end
      if (beat) begin
        shadow <= {cfg_bit, shadow[W-1:1]};
      end
    end
  end

  assign done_c = beat && (count == CW'(W - 1));

endmodule

// File: rtl/prog_logic_cell.sv
// Programmable logic cell: 2**N_IN-entry truth table evaluated with 1-cycle latency, reloadable serially.
// Optional PROG_LOGIC_CELL_STATS_EN adds ones_cnt, a saturating count of delivered 1 results.
module prog_logic_cell
  import plc_pkg::*;
#(
  parameter int unsigned              N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]     TT_RESET = (1<<N_IN)'(TT_DEFAULT_3)
) (
  input  logic                    clk,
  input  logic                    rst,
  prog_logic_cell_if.slave        bus
`ifdef PROG_LOGIC_CELL_STATS_EN
  ,
  output logic [15:0]             ones_cnt
`endif
);

  localparam int unsigned W = 1 << N_IN;

  plc_state_e       state;
  plc_state_e       state_nxt;
  logic             cfg_rdy_c;
  logic             in_rdy_c;
  logic             commit_c;
  logic             cfg_fire;
  logic             in_fire;
  logic             load_done_c;
  logic [W-1:0]     shadow;
  logic [W-1:0]     active_table;
  logic             out_valid;
  logic             out_y;

  assign cfg_fire = bus.cfg_valid && cfg_rdy_c;
  assign in_fire  = bus.in_valid && in_rdy_c;

  plc_tt_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .beat    (cfg_fire),
    .clear   (commit_c),
    .cfg_bit (bus.cfg_bit),
    .shadow  (shadow),
    .done_c  (load_done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (cfg_fire) state_nxt = LOAD;
      LOAD:    if (load_done_c) state_nxt = COMMIT;
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // COMMIT blocks both streams for its single cycle so the table swap is atomic.
  always_comb begin
    cfg_rdy_c = 1'b0;
    in_rdy_c  = 1'b0;
    commit_c  = 1'b0;
    unique case (state)
      RUN, LOAD: begin
        cfg_rdy_c = 1'b1;
        in_rdy_c  = !out_valid || bus.out_ready;
      end
      COMMIT:  commit_c = 1'b1;
      default: commit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_table <= TT_RESET;
      out_valid    <= 1'b0;
      out_y        <= 1'b0;
    end else begin
      if (commit_c) begin
        active_table <= shadow;
      end
      if (in_fire) begin
        out_valid <= 1'b1;
        out_y     <= active_table[bus.in_x];
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready = cfg_rdy_c;
  assign bus.in_ready  = in_rdy_c;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = out_y;

`ifdef PROG_LOGIC_CELL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (out_valid && bus.out_ready && out_y && (ones_cnt != 16'hFFFF)) begin
      ones_cnt <= ones_cnt + 16'd1;
    end
  end
`endif

endmodule
